// File: rtl/booth_mul_arbiter.sv
// Round-robin front end that shares one booth multiplier between two requesters,
// launching each operation with a start pulse and bounding the wait with a timeout.
module booth_mul_arbiter #(
  parameter int N       = 5,
  parameter int TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [N-1:0]     a0,
  input  logic [N-1:0]     b0,
  input  logic [N-1:0]     a1,
  input  logic [N-1:0]     b1,
  output logic [1:0]       gnt,
  output logic [1:0]       rsp_valid,
  output logic [2*N-1:0]   rsp_product,
  output logic             rsp_err,
  output logic             busy,
  output logic             mul_start,
  output logic [N-1:0]     mul_a,
  output logic [N-1:0]     mul_b,
  input  logic [2*N-1:0]   mul_product,
  input  logic             mul_done
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t          state_reg;
  logic            owner_reg;
  logic            pri_reg;
  logic [TW-1:0]   timer_reg;
  logic            owner_next;

  // A lone request wins outright; only a tie consults the priority pointer.
  always_comb begin
    owner_next = req[1];
    if (req == 2'b11) begin
      owner_next = pri_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      owner_reg   <= 1'b0;
      pri_reg     <= 1'b0;
      timer_reg   <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      rsp_product <= '0;
      rsp_err     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req != 2'b00) begin
            owner_reg <= owner_next;
            mul_a     <= owner_next ? a1 : a0;
            mul_b     <= owner_next ? b1 : b0;
            timer_reg <= '0;
            state_reg <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          // Completion is checked before the timeout so a last-cycle done still counts.
          if (mul_done) begin
            rsp_product <= mul_product;
            rsp_err     <= 1'b0;
            state_reg   <= ST_RESP;
          end else if (timer_reg == TIMER_LAST) begin
            rsp_product <= '0;
            rsp_err     <= 1'b1;
            state_reg   <= ST_RESP;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        ST_RESP: begin
          pri_reg   <= ~owner_reg;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign mul_start = (state_reg == ST_LAUNCH);
  assign gnt       = (state_reg == ST_LAUNCH) ? (owner_reg ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid = (state_reg == ST_RESP)   ? (owner_reg ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter: a behavioural multiplier plus grant and
// response scoreboards filled as each request is driven.
`timescale 1ns/1ps
module tb_booth_mul_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [4:0]  a0, b0, a1, b1;
  logic [1:0]  gnt;
  logic [1:0]  rsp_valid;
  logic [9:0]  rsp_product;
  logic        rsp_err;
  logic        busy;
  logic        mul_start;
  logic [4:0]  mul_a, mul_b;
  logic [9:0]  mul_product;
  logic        mul_done;

  logic        model_done;
  logic        tb_done;
  int          model_cnt;
  int          model_lat;
  bit          hang;
  logic signed [9:0] ma_x, mb_x, model_full;

  int n_vec;
  int n_mis;

  typedef struct { int who; int a; int b; } gexp_t;
  typedef struct { int who; int prod; int err; } rexp_t;
  gexp_t gnt_q[$];
  rexp_t rsp_q[$];
  gexp_t g_m;
  rexp_t r_m;

  booth_mul_arbiter #(.N(5), .TIMEOUT(32)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_product(rsp_product),
    .rsp_err(rsp_err), .busy(busy), .mul_start(mul_start),
    .mul_a(mul_a), .mul_b(mul_b),
    .mul_product(mul_product), .mul_done(mul_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural multiplier: product latched at start, done after model_lat edges.
  assign ma_x = {{5{mul_a[4]}}, mul_a};
  assign mb_x = {{5{mul_b[4]}}, mul_b};
  assign model_full = ma_x * mb_x;
  assign mul_done = model_done | tb_done;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_cnt   <= 0;
      model_done  <= 1'b0;
      mul_product <= '0;
    end else begin
      model_done <= 1'b0;
      if (mul_start) begin
        mul_product <= model_full;
        model_cnt   <= hang ? 0 : model_lat;
      end else if (model_cnt > 0) begin
        model_cnt <= model_cnt - 1;
        if (model_cnt == 1) model_done <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_gnt(input int who, input int a, input int b);
    gexp_t g;
    g.who = who; g.a = a; g.b = b;
    gnt_q.push_back(g);
  endtask

  task automatic push_op(input int who, input int a, input int b, input int err);
    rexp_t r;
    push_gnt(who, a, b);
    r.who = who; r.prod = err ? 0 : a * b; r.err = err;
    rsp_q.push_back(r);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_mul_start"}, mul_start, 0);
    check({tag, "_mul_a"}, mul_a, 0);
    check({tag, "_mul_b"}, mul_b, 0);
    check({tag, "_rsp_product"}, rsp_product, 0);
  endtask

  task automatic wait_gnt(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (gnt != 2'b00);
    end
    check({tag, "_gnt_seen"}, seen, 1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && rsp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check({tag, "_drain"}, rsp_q.size(), 0);
    @(negedge clk);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  // One isolated operation; lat counts negedges from the grant cycle to the response.
  task automatic run_op(input string tag, input int who, input int a, input int b,
                        input int err, output int lat);
    bit seen = 1'b0;
    lat = 0;
    if (who == 0) begin a0 = 5'(a); b0 = 5'(b); end
    else          begin a1 = 5'(a); b1 = 5'(b); end
    push_op(who, a, b, err);
    req = (who == 0) ? 2'b01 : 2'b10;
    wait_gnt(tag);
    req = 2'b00;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      lat++;
      seen = (rsp_valid != 2'b00);
    end
    check({tag, "_rsp_seen"}, seen, 1);
    #1;
    @(negedge clk);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  // Grant and response monitors.
  always @(negedge clk) begin
    if (gnt != 2'b00 || mul_start) begin
      if (gnt_q.size() == 0) begin
        check("gnt_unexpected", {gnt, mul_start}, 0);
      end else begin
        g_m = gnt_q.pop_front();
        check("gnt", gnt, (g_m.who == 0) ? 1 : 2);
        check("mul_start", mul_start, 1);
        check("mul_a", $signed(mul_a), g_m.a);
        check("mul_b", $signed(mul_b), g_m.b);
      end
    end
    if (rsp_valid != 2'b00) begin
      if (rsp_q.size() == 0) begin
        check("rsp_unexpected", rsp_valid, 0);
      end else begin
        r_m = rsp_q.pop_front();
        check("rsp_valid", rsp_valid, (r_m.who == 0) ? 1 : 2);
        check("rsp_product", $signed(rsp_product), r_m.prod);
        check("rsp_err", rsp_err, r_m.err);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int grants;
    n_vec = 0; n_mis = 0;
    rst = 1'b0; req = 2'b00; tb_done = 1'b0; hang = 1'b0; model_lat = 7;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b1;

    run_op("single", 0, -7, 9, 0, lat);

    run_op("ext_neg", 0, -16, -16, 0, lat);
    run_op("ext_mix", 0, 15, -16, 0, lat);

    hang = 1'b1;
    run_op("timeout", 1, 2, 2, 1, lat);
    check("timeout_latency", lat, 33);
    check("timeout_err_held", rsp_err, 1);
    check("timeout_prod_held", $signed(rsp_product), 0);
    hang = 1'b0;
    run_op("recover", 1, 3, -2, 0, lat);
    check("recover_err_held", rsp_err, 0);

    // Both requesters held high: grants must alternate starting with requester 0.
    a0 = 5'd3; b0 = 5'd4; a1 = -5'sd5; b1 = -5'sd6;
    push_op(0, 3, 4, 0);
    push_op(1, -5, -6, 0);
    push_op(0, 3, 4, 0);
    push_op(1, -5, -6, 0);
    req = 2'b11;
    grants = 0;
    for (int i = 0; i < 200 && grants < 4; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) grants++;
    end
    req = 2'b00;
    check("contend_grants", grants, 4);
    drain("contend");

    tb_done = 1'b1;
    @(negedge clk);
    tb_done = 1'b0;
    repeat (3) @(negedge clk);
    check("spurious_prod", $signed(rsp_product), 30);
    check("spurious_busy", busy, 0);

    // Done arrives in the same cycle the timer reaches its last count.
    hang = 1'b1;
    a0 = 5'd5; b0 = -5'sd3;
    push_op(0, 5, -3, 0);
    req = 2'b01;
    wait_gnt("collide");
    req = 2'b00;
    repeat (32) @(negedge clk);
    tb_done = 1'b1;
    @(negedge clk);
    tb_done = 1'b0;
    check("collide_rsp", rsp_valid, 1);
    #1;
    @(negedge clk);
    check("collide_busy_after", busy, 0);
    hang = 1'b0;

    // Reset while waiting on requester 0; the aborted operation must stay silent.
    hang = 1'b1;
    a0 = 5'd6; b0 = 5'd7;
    push_gnt(0, 6, 7);
    req = 2'b01;
    wait_gnt("abort");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    hang = 1'b0;
    push_op(0, 6, 7, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_gnt", gnt, 1);
    req = 2'b00;
    drain("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/booth_mul_arbiter.md
Name: booth_mul_arbiter

Overview:
- Shares one booth_multiplier instance between two independent requesters. Requester 0 is the keypad operand FSM; requester 1 is the self-test or demo sequencer.
- Arbitrates round-robin and latches the winner's operands.
- Issues the single-cycle start pulse, waits for done, and guards against a hung multiplier with a timeout.
- Returns the signed product, or an error flag, to the requester that was granted.

Parameters:
- N, 5, operand width in bits (signed two's complement); product is 2N bits.
- TIMEOUT, 32, maximum cycles spent in WAIT before declaring an error; legal range ≥ N+4.

Ports:
- clk  in  1  system clock (27 MHz).
- rst  in  1  reset, asynchronous, active-low.
- req  in  2  level request per requester; requester i holds a_i/b_i stable while req[i]=1.
- a0  in  N  signed multiplicand, requester 0.
- b0  in  N  signed multiplier, requester 0.
- a1  in  N  signed multiplicand, requester 1.
- b1  in  N  signed multiplier, requester 1.
- gnt  out  2  one-hot, one-cycle grant pulse; operands are captured at this point.
- rsp_valid  out  2  one-hot, one-cycle response pulse to the owner.
- rsp_product  out  2N  signed result; held until the next capture.
- rsp_err  out  1  1 = timeout on the last operation; valid with rsp_valid, held afterwards.
- busy  out  1  high in every state other than IDLE.
- mul_start  out  1  start pulse to the multiplier.
- mul_a  out  N  latched multiplicand to the multiplier.
- mul_b  out  N  latched multiplier to the multiplier.
- mul_product  in  2N  multiplier product.
- mul_done  in  1  multiplier completion pulse.

Behaviour:
- FSM states:
  - IDLE: no operation in progress.
  - LAUNCH: exactly 1 cycle.
  - WAIT: multiplier running.
  - RESP: exactly 1 cycle.
- Reset (async, any state):
  - State goes to IDLE; priority pointer pri=0.
  - gnt, rsp_valid, rsp_err, busy and mul_start = 0.
  - mul_a, mul_b, rsp_product = 0; timer = 0.
  - An operation cut short by reset produces no response. The multiplier shares the same rst.
- IDLE → LAUNCH, at the edge where req≠0:
  - Owner selection: if only one req bit is set, that requester wins. If both are set, the requester indexed by pri wins.
  - On that edge: owner is latched; mul_a/mul_b are loaded from the owner's a/b; timer is cleared.
- LAUNCH:
  - gnt[owner]=1 and mul_start=1, both combinational decodes of state, in the same cycle.
  - Next state is WAIT unconditionally.
- WAIT, evaluated in priority order each cycle:
  1. mul_done=1: rsp_product ← mul_product, rsp_err ← 0, go to RESP.
  2. Otherwise, timer==TIMEOUT-1: rsp_product ← 0, rsp_err ← 1, go to RESP.
  3. Otherwise: timer increments.
  - If done and timeout coincide, done wins.
- RESP:
  - rsp_valid[owner]=1.
  - pri ← ~owner (the other requester gets priority next).
  - Next state is IDLE.
- Response latency: req sampled at edge k gives gnt/mul_start in cycle k+1. mul_done sampled at edge d gives rsp_valid in cycle d+1.
- Back-to-back: a req still high in the IDLE cycle after RESP is granted at that edge. Minimum operation period is 4 cycles plus the multiplier latency.
- mul_done outside WAIT is ignored. It must not alter rsp_product.
- Request lifetime:
  - req changes during LAUNCH, WAIT or RESP are ignored.
  - The non-owner's held req is serviced afterwards.
  - A req deasserted before selection is never granted.
  - The owner's req is not re-sampled until IDLE; the requester drops req after gnt, or it is served again.
- Arithmetic: operands pass through unmodified as signed N-bit values. The product is not sign-extended or truncated (2N bits). Range checking is the requester's job.
- Timer width is clog2(TIMEOUT) bits; it never wraps because WAIT exits first.

Test Plan:
- Single request, operand and product values in decimal:
  - Stimulus: after reset, req=01, a0=-7, b0=9; model multiplier returns done 7 cycles after start.
  - Response: gnt=01 for 1 cycle with mul_start=1 and mul_a=-7, mul_b=9; rsp_valid=01 for 1 cycle; rsp_product=-63; rsp_err=0; busy low afterwards.
- Contention with fairness:
  - Stimulus: req=11 held continuously; a0=3, b0=4; a1=-5, b1=-6.
  - Response: grants go 0, 1, 0, 1 in turn; responses are 12 (to requester 0) and 30 (to requester 1); never two grants to one requester while the other is waiting.
- Timeout:
  - Stimulus: req=10, a1=2, b1=2; mul_done held at 0.
  - Response: exactly TIMEOUT=32 cycles after entering WAIT, rsp_valid=10, rsp_err=1, rsp_product=0. The next operation (done returned normally) clears rsp_err to 0.
- Spurious done and done/timeout collision:
  - Stimulus: pulse mul_done in IDLE; later, assert done in the same cycle as timer=TIMEOUT-1.
  - Response: the idle pulse produces no rsp and rsp_product is unchanged; the collision gives rsp_err=0 with the product captured.
- Reset mid-operation:
  - Stimulus: drop rst while in WAIT for requester 0; release rst with req=01 still high.
  - Response: all outputs read 0 during reset and no rsp_valid is issued for the aborted operation. A fresh gnt=01 arrives 1 cycle after the first sampling edge following release; pri=0.
- Extremes:
  - Stimulus: a0=-16, b0=-16 (N=5), then a0=15, b0=-16.
  - Response: rsp_product=256 (10'sd256), then -240; no truncation.
